spi_periph_t: RTL
=================

SPI_PERIPH_T -- requirements
Module: spi_periph_t

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets synchroniser depth on sck/cs/mosi inputs; legal values 2 or 3.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wen  input  1  bus write strobe; register selected by addr[7:0].
REQ-005 addr  input  32  bus address; only addr[7:0] decoded.
REQ-006 wdata  input  32  bus write data.
REQ-007 rdata  output  32  registered bus read data.
REQ-008 spi_sck  input  1  serial clock from external controller (mode 0: CPOL=0, CPHA=0).
REQ-009 spi_cs  input  1  chip select, active-low.
REQ-010 spi_mosi  input  1  serial data in, MSB first.
REQ-011 spi_miso  output  1  serial data out, MSB first.
REQ-012 spi_miso_oe  output  1  output enable for miso pad driver; 1 only while synchronised cs is low.

Function
REQ-013 Register map: 0x0 TXDATA (W: byte to send; R: tx_buf), 0x8 RXDATA (R: last received byte), 0xC STATUS (R/W), 0x10 COUNT (R: bytes received since reset, 16-bit, wraps 0xFFFF->0).
REQ-014 STATUS bits: [0] rx_pending, [1] busy (sync cs low), [2] overrun, [3] tx_empty; others read 0.
REQ-015 STATUS write: wdata[0]=1 clears rx_pending, wdata[2]=1 clears overrun; other bits ignored.
REQ-016 Reads: when wen=0, rdata updates one clk after addr with selected register; unmapped offsets leave rdata unchanged; rdata holds while wen=1.
REQ-017 TXDATA write: tx_buf<=wdata[7:0], tx_empty<=0, in same clk.
REQ-018 sck, cs, mosi each pass through SYNC_STAGES flops; edges detected from last two synchronised samples.
REQ-019 Controller sck high and low phases each SHALL be >= 4 clk cycles; behaviour outside this is undefined.
REQ-020 States: IDLE (cs high) and SHIFT (cs low); cs falling edge IDLE->SHIFT, cs rising edge SHIFT->IDLE.
REQ-021 On cs falling edge: bit_cnt<=0; tx_sr<= tx_empty ? 8'hFF : tx_buf; tx_empty<=1.
REQ-022 spi_miso = tx_sr[7] while spi_miso_oe=1; 1 otherwise.
REQ-023 On sck rising edge in SHIFT: rx_sr<={rx_sr[6:0], mosi_sync}; bit_cnt<=bit_cnt+1 (3-bit, wraps 7->0).
REQ-024 On rising edge completing bit 8 (bit_cnt 7->0): rx_data<={rx_sr[6:0],mosi_sync}; rx_pending<=1; COUNT+1; overrun<=1 if rx_pending already 1; rx_data overwritten regardless.
REQ-025 On sck falling edge in SHIFT: if bit_cnt==0 reload tx_sr per REQ-021 rule (including tx_empty<=1), else tx_sr<={tx_sr[6:0],1'b1}.
REQ-026 Simultaneous TXDATA write and reload: reload uses old tx_buf/tx_empty; afterwards tx_buf=new value, tx_empty=0.
REQ-027 Simultaneous STATUS clear and byte completion: set wins (rx_pending=1; overrun set per REQ-024).
REQ-028 cs rising mid-byte (bit_cnt!=0): partial byte discarded, no rx_pending/COUNT update, bit_cnt<=0, miso_oe<=0 next clk.
REQ-029 sck edges while cs high ignored.

Reset
REQ-030 On reset: rdata=0, tx_buf=0, tx_sr=8'hFF, rx_sr=0, rx_data=0, bit_cnt=0, COUNT=0, rx_pending=0, overrun=0, tx_empty=1, state IDLE, synchronisers to sck=0/cs=1/mosi=0, spi_miso=1, spi_miso_oe=0.
REQ-031 Reset asserted mid-transfer aborts immediately; after release, module waits for fresh cs falling edge before shifting.

Verification
REQ-032 Write TXDATA=0xA5, controller sends 0x3C (sck 8 clk/phase) -> miso bits 1,0,1,0,0,1,0,1; RXDATA=0x3C; STATUS=0x0B during cs low, 0x09 after cs high; COUNT=1.
REQ-033 Two bytes 0x11,0x22 in one cs frame, no TXDATA reload, no status clear -> second miso byte 0xFF; RXDATA=0x22; STATUS[2]=1; COUNT=2.
REQ-034 STATUS write 0x5 after REQ-033 -> STATUS reads 0x08; subsequent byte 0x77 -> STATUS[0]=1, STATUS[2]=0.
REQ-035 cs raised after 5 sck rising edges of 0xF0 -> RXDATA unchanged, COUNT unchanged, spi_miso_oe=0; next full byte 0x81 received correctly.
REQ-036 reset pulsed after 3 bits -> all registers per REQ-030; next frame 0x42 with TXDATA unwritten -> miso 0xFF, RXDATA=0x42.
REQ-037 TXDATA write on same clk as reload falling edge -> current byte shifts old value/0xFF, tx_empty=0, next byte shifts new value.

Source files
------------

// File: rtl/spi_periph_t.sv
// Mode-0 SPI peripheral with a small memory-mapped register file.
// Serial inputs are resynchronised into clk; all shifting is driven by detected sck/cs edges.
module spi_periph_t #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        spi_sck,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_COUNT  = 8'h10;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  tx_buf_q, tx_buf_d;
    logic        tx_empty_q, tx_empty_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic [7:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_pending_q, rx_pending_d;
    logic        overrun_q, overrun_d;
    logic [15:0] count_q, count_d;
    logic [31:0] rdata_q, rdata_d;

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall, cs_fall, cs_rise;
    logic       reload, byte_done;
    logic [7:0] offset;
    logic [3:0] status;
    logic       unused_bits;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    assign offset      = addr[7:0];
    assign status      = {tx_empty_q, overrun_q, (state_q == ST_SHIFT), rx_pending_q};
    assign unused_bits = ^{addr[31:8], wdata[31:8]};

    // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        tx_buf_d     = tx_buf_q;
        tx_empty_d   = tx_empty_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        rx_data_d    = rx_data_q;
        rx_pending_d = rx_pending_q;
        overrun_d    = overrun_q;
        count_d      = count_q;
        rdata_d      = rdata_q;
        reload       = 1'b0;
        byte_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 3'd0;
                    reload    = 1'b1;
                end
            end
            ST_SHIFT: begin
                // A cs release mid-byte simply drops the partial byte.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sck_rise) begin
                    rx_sr_d   = {rx_sr_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    byte_done = (bit_cnt_q == 3'd7);
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) reload = 1'b1;
                    else tx_sr_d = {tx_sr_q[6:0], 1'b1};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reload samples the old buffer; a same-cycle TXDATA write below still lands afterwards.
        if (reload) begin
            tx_sr_d    = tx_empty_q ? 8'hFF : tx_buf_q;
            tx_empty_d = 1'b1;
        end

        if (wen && offset == OFF_STATUS) begin
            if (wdata[0]) rx_pending_d = 1'b0;
            if (wdata[2]) overrun_d    = 1'b0;
        end

        // Byte completion is applied after the clear so that a set always wins.
        if (byte_done) begin
            rx_data_d    = {rx_sr_q[6:0], mosi_s};
            rx_pending_d = 1'b1;
            count_d      = count_q + 16'd1;
            if (rx_pending_q) overrun_d = 1'b1;
        end

        if (wen && offset == OFF_TXDATA) begin
            tx_buf_d   = wdata[7:0];
            tx_empty_d = 1'b0;
        end

        if (!wen) begin
            case (offset)
                OFF_TXDATA: rdata_d = {24'd0, tx_buf_q};
                OFF_RXDATA: rdata_d = {24'd0, rx_data_q};
                OFF_STATUS: rdata_d = {28'd0, status};
                OFF_COUNT:  rdata_d = {16'd0, count_q};
                default:    rdata_d = rdata_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q   <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            tx_buf_q     <= 8'h00;
            tx_empty_q   <= 1'b1;
            tx_sr_q      <= 8'hFF;
            rx_sr_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_pending_q <= 1'b0;
            overrun_q    <= 1'b0;
            count_q      <= 16'd0;
            rdata_q      <= 32'd0;
        end else begin
            sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q   <= sck_s;
            cs_prev_q    <= cs_s;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_buf_q     <= tx_buf_d;
            tx_empty_q   <= tx_empty_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            rx_data_q    <= rx_data_d;
            rx_pending_q <= rx_pending_d;
            overrun_q    <= overrun_d;
            count_q      <= count_d;
            rdata_q      <= rdata_d;
        end
    end

    assign rdata       = rdata_q;
    assign spi_miso_oe = (state_q == ST_SHIFT);
    assign spi_miso    = spi_miso_oe ? tx_sr_q[7] : 1'b1;

endmodule
